// File: rtl/sdelta_decoder_pkg.sv
// Shared definitions for the signed delta decoder.
//   state_e      : decoder FSM states
//   sat_max/min  : most positive / most negative signed value of a given width,
//                  returned in 64 bits; callers cast down to their width.
package sdelta_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_e;

    function automatic logic [63:0] sat_max(input int unsigned dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned dw);
        return ~sat_max(dw);
    endfunction

endpackage

// File: rtl/sdelta_decoder_ssat_add.sv
// Combinational signed add with overflow detection and optional clamp.
//   a, b : signed DATAWIDTH operands
//   res  : a + b, wrapped (SATURATE=0) or clamped to MIN/MAX (SATURATE=1)
//   of   : the true sum did not fit in DATAWIDTH bits
module ssat_add
    import sdelta_decoder_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 2,
    parameter int unsigned SATURATE  = 0
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] res,
    output logic                 of
);

    localparam logic [DATAWIDTH-1:0] MAXV = DATAWIDTH'(sat_max(DATAWIDTH));
    localparam logic [DATAWIDTH-1:0] MINV = DATAWIDTH'(sat_min(DATAWIDTH));

    logic [DATAWIDTH:0] sum;

    always_comb begin
        sum = {a[DATAWIDTH-1], a} + {b[DATAWIDTH-1], b};
        // Extended sign bit disagreeing with the result MSB means overflow.
        of  = sum[DATAWIDTH] ^ sum[DATAWIDTH-1];
        res = sum[DATAWIDTH-1:0];
        if (SATURATE != 0 && of) begin
            res = sum[DATAWIDTH] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/sdelta_decoder.sv
// Signed delta stream decoder: x[n] = x[n-1] + d[n], seeded by a start pulse.
//   Clk, Rst          : clock, synchronous active-high reset
//   start, seed,
//   frame_len         : begin a frame (IDLE only) with x[0]=seed, frame_len deltas
//   in_valid/in_ready,
//   delta             : delta input stream
//   out_valid/out_ready,
//   value             : reconstructed sample stream (one register stage)
//   ovf               : some add in this frame overflowed (sticky until next start)
//   busy              : FSM not idle
//   done              : one-cycle pulse when the frame has fully completed
module sdelta_decoder
    import sdelta_decoder_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 2,
    parameter int unsigned CNTW      = 8,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] seed,
    input  logic [CNTW-1:0]      frame_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] delta,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] value,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic [DATAWIDTH-1:0] value_q, value_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;

    logic                 accept;
    logic                 take;
    logic [DATAWIDTH-1:0] add_res;
    logic                 add_of;

    ssat_add #(
        .DATAWIDTH(DATAWIDTH),
        .SATURATE (SATURATE)
    ) u_add (
        .a  (acc_q),
        .b  (delta),
        .res(add_res),
        .of (add_of)
    );

    always_comb begin
        in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        take     = out_valid_q && out_ready;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        value_d     = value_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = seed;
                    cnt_d   = frame_len;
                    ovf_d   = 1'b0;
                    state_d = (frame_len != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_d       = add_res;
                    value_d     = add_res;
                    out_valid_d = 1'b1;
                    ovf_d       = ovf_q | add_of;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end else if (take) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (take || !out_valid_q) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            value_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            value_q     <= value_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        value     = value_q;
        ovf       = ovf_q;
        done      = done_q;
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_sdelta_decoder.sv
module tb_sdelta_decoder;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] seed = '0;
    logic [7:0] frame_len = '0;
    logic       in_valid = 1'b0;
    logic [7:0] delta = '0;
    logic       out_ready = 1'b1;

    logic       w_in_ready, w_out_valid, w_ovf, w_busy, w_done;
    logic [7:0] w_value;
    logic       s_in_ready, s_out_valid, s_ovf, s_busy, s_done;
    logic [7:0] s_value;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    sdelta_decoder #(.DATAWIDTH(8), .CNTW(8), .SATURATE(0)) u_wrap (
        .Clk(Clk), .Rst(Rst), .start(start), .seed(seed), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(w_in_ready), .delta(delta),
        .out_valid(w_out_valid), .out_ready(out_ready), .value(w_value),
        .ovf(w_ovf), .busy(w_busy), .done(w_done)
    );

    sdelta_decoder #(.DATAWIDTH(8), .CNTW(8), .SATURATE(1)) u_sat (
        .Clk(Clk), .Rst(Rst), .start(start), .seed(seed), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .delta(delta),
        .out_valid(s_out_valid), .out_ready(out_ready), .value(s_value),
        .ovf(s_ovf), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int sv(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic start_frame(input int s, input int len);
        seed      = 8'(s);
        frame_len = 8'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Feed one delta with out_ready high, check the resulting sample.
    task automatic feed(input string tag, input int d, input int exp);
        delta    = 8'(d);
        in_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, int'(w_in_ready), 1);
        tick();
        chk({tag, "_val"}, sv(w_value), exp);
        chk({tag, "_vld"}, int'(w_out_valid), 1);
    endtask

    // Last sample is in the output register: handshake it, then expect done.
    task automatic finish_frame(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk({tag, "_fin_vld"}, int'(w_out_valid), 0);
        chk({tag, "_fin_done0"}, int'(w_done), 0);
        tick();
        chk({tag, "_done"}, int'(w_done), 1);
        chk({tag, "_idle"}, int'(w_busy), 0);
        tick();
        chk({tag, "_done_clr"}, int'(w_done), 0);
    endtask

    initial begin
        // Reset state
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        chk("rst_value", sv(w_value), 0);
        chk("rst_vld", int'(w_out_valid), 0);
        chk("rst_busy", int'(w_busy), 0);
        chk("rst_done", int'(w_done), 0);
        chk("rst_ovf", int'(w_ovf), 0);
        chk("rst_rdy", int'(w_in_ready), 0);

        // Basic frame: 10 +5 -3 -20
        start_frame(10, 3);
        chk("b_busy", int'(w_busy), 1);
        chk("b_vld0", int'(w_out_valid), 0);
        feed("b0", 5, 15);
        feed("b1", -3, 12);
        feed("b2", -20, -8);
        chk("b_ovf", int'(w_ovf), 0);
        finish_frame("b");
        chk("b_persist", sv(w_value), -8);

        // Positive overflow: 120 + 10
        start_frame(120, 1);
        feed("op", 10, -126);
        chk("op_ovf", int'(w_ovf), 1);
        chk("op_sat_val", sv(s_value), 127);
        chk("op_sat_ovf", int'(s_ovf), 1);
        finish_frame("op");
        chk("op_ovf_hold", int'(w_ovf), 1);
        chk("op_sat_done_seen", int'(s_busy), 0);

        // Negative overflow: -120 + -10
        start_frame(-120, 1);
        feed("on", -10, 126);
        chk("on_ovf", int'(w_ovf), 1);
        chk("on_sat_val", sv(s_value), -128);
        chk("on_sat_ovf", int'(s_ovf), 1);
        finish_frame("on");

        // Backpressure: 0 +1 +2 +3 +4 with out_ready low for 3 cycles
        start_frame(0, 4);
        chk("bp_ovf_clr", int'(w_ovf), 0);
        feed("bp0", 1, 1);
        out_ready = 1'b0;
        delta     = 8'd2;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy_low", int'(w_in_ready), 0);
            chk("bp_sat_rdy_low", int'(s_in_ready), 0);
            tick();
            chk("bp_hold_val", sv(w_value), 1);
            chk("bp_hold_vld", int'(w_out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_back", int'(w_in_ready), 1);
        tick();
        chk("bp1_val", sv(w_value), 3);
        feed("bp2", 3, 6);
        feed("bp3", 4, 10);
        finish_frame("bp");

        // Back-to-back len=8: running sums of 1..8
        start_frame(0, 8);
        begin
            int exp_acc = 0;
            for (int i = 1; i <= 8; i++) begin
                exp_acc += i;
                feed("b2b", i, exp_acc);
            end
        end
        finish_frame("b2b");

        // start while RUN is ignored
        start_frame(5, 2);
        seed  = 8'd99;
        start = 1'b1;
        feed("ig0", 1, 6);
        start = 1'b0;
        feed("ig1", 2, 8);
        finish_frame("ig");

        // Zero-length frame
        start_frame(33, 0);
        chk("z_busy", int'(w_busy), 1);
        chk("z_vld", int'(w_out_valid), 0);
        chk("z_done0", int'(w_done), 0);
        tick();
        chk("z_done", int'(w_done), 1);
        chk("z_idle", int'(w_busy), 0);
        chk("z_vld2", int'(w_out_valid), 0);
        tick();
        chk("z_done_clr", int'(w_done), 0);
        chk("z_val_keep", sv(w_value), 8);

        // Mid-frame reset after 2 of 5 deltas
        start_frame(0, 5);
        feed("mr0", 3, 3);
        feed("mr1", 4, 7);
        in_valid = 1'b0;
        Rst      = 1'b1;
        tick();
        Rst      = 1'b0;
        chk("mr_vld", int'(w_out_valid), 0);
        chk("mr_busy", int'(w_busy), 0);
        chk("mr_val", sv(w_value), 0);
        chk("mr_done", int'(w_done), 0);
        tick();
        chk("mr_done2", int'(w_done), 0);
        start_frame(-5, 2);
        feed("mr2", 2, -3);
        feed("mr3", 2, -1);
        finish_frame("mr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
